cim_oai_mac_seq: RTL and testbench

//  Bit-serial sequencer for one 4-bit OAI multiplier cell (e = ~((a|{4{c}}) & (b|{4{d}}))).

---
 rtl/cim_pkg.sv | 16 +
 rtl/cim_shift_acc.sv | 38 +++
 rtl/cim_oai_mac_seq.sv | 177 +++++++++++++++++
 tb/tb_cim_oai_mac_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared types and idle-drive constants for the CIM OAI multiplier sequencer.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MULT_W = 4;

  // With c=d=1 the OAI cell output is forced to zero regardless of a/b.
  localparam logic [MULT_W-1:0] IDLE_MULT_AB = 4'hF;
  localparam logic              IDLE_MULT_CD = 1'b1;

endpackage

// File: rtl/cim_shift_acc.sv
// MSB-first shift-add accumulator: acc <= (acc<<1) +/- addend, with synchronous clear.
module cim_shift_acc #(
  parameter int ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic             sub,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (sub) begin
      acc_d = (acc_q << 1) - addend;
    end else if (add) begin
      acc_d = (acc_q << 1) + addend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cim_oai_mac_seq.sv
// Bit-serial two-row dot-product sequencer driving one external 4-bit OAI multiplier cell.
// Optional SIGNED_ACT_EN: activations are two's complement (MSB step subtracts).
module cim_oai_mac_seq
  import cim_pkg::*;
#(
  parameter int ACT_W = 4,
  parameter int W_W   = 4,
  parameter int ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_W-1:0]   w0,
  input  logic [W_W-1:0]   w1,
  input  logic [ACT_W-1:0] x0,
  input  logic [ACT_W-1:0] x1,
  output logic [W_W-1:0]   mult_a,
  output logic [W_W-1:0]   mult_b,
  output logic             mult_c,
  output logic             mult_d,
  input  logic [W_W-1:0]   mult_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result
);

  localparam int K_W = (ACT_W > 1) ? $clog2(ACT_W) : 1;

  if (W_W != MULT_W) begin : g_bad_w_w
    $error("cim_oai_mac_seq: W_W must equal the multiplier width (4)");
  end
  if (ACC_W < W_W + ACT_W + 1) begin : g_bad_acc_w
    $error("cim_oai_mac_seq: ACC_W too narrow for overflow-free accumulation");
  end

  state_e           state_d, state_q;
  logic [ACT_W-1:0] x0_d, x0_q, x1_d, x1_q;
  logic [K_W-1:0]   k_d, k_q;
  logic             phase_d, phase_q;
  logic [W_W-1:0]   e0_d, e0_q;
  logic [W_W-1:0]   mult_a_d, mult_a_q, mult_b_d, mult_b_q;
  logic             mult_c_d, mult_c_q, mult_d_d, mult_d_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             acc_clr, acc_add, acc_sub;
  logic [ACC_W-1:0] addend;

  // Both row partial products of one bit step, zero-extended before summing.
  assign addend = ACC_W'(e0_q) + ACC_W'(mult_e);

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    k_d         = k_q;
    phase_d     = phase_q;
    e0_d        = e0_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    mult_c_d    = mult_c_q;
    mult_d_d    = mult_d_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    acc_sub     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x0_d       = x0;
          x1_d       = x1;
          k_d        = K_W'(ACT_W - 1);
          phase_d    = 1'b0;
          e0_d       = '0;
          acc_clr    = 1'b1;
          mult_a_d   = ~w0;
          mult_b_d   = ~w1;
          mult_c_d   = ~x0[ACT_W-1];
          mult_d_d   = IDLE_MULT_CD;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!phase_q) begin
          e0_d     = mult_e;
          phase_d  = 1'b1;
          mult_c_d = IDLE_MULT_CD;
          mult_d_d = ~x1_q[k_q];
        end else begin
          phase_d = 1'b0;
`ifdef SIGNED_ACT_EN
          acc_sub = (k_q == K_W'(ACT_W - 1));
          acc_add = !acc_sub;
`else
          acc_add = 1'b1;
`endif
          if (k_q == '0) begin
            mult_c_d    = IDLE_MULT_CD;
            mult_d_d    = IDLE_MULT_CD;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            k_d      = k_q - K_W'(1);
            mult_c_d = ~x0_q[k_q - K_W'(1)];
            mult_d_d = IDLE_MULT_CD;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          mult_a_d    = W_W'(IDLE_MULT_AB);
          mult_b_d    = W_W'(IDLE_MULT_AB);
          mult_c_d    = IDLE_MULT_CD;
          mult_d_d    = IDLE_MULT_CD;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      k_q         <= '0;
      phase_q     <= 1'b0;
      e0_q        <= '0;
      mult_a_q    <= W_W'(IDLE_MULT_AB);
      mult_b_q    <= W_W'(IDLE_MULT_AB);
      mult_c_q    <= IDLE_MULT_CD;
      mult_d_q    <= IDLE_MULT_CD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      k_q         <= k_d;
      phase_q     <= phase_d;
      e0_q        <= e0_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      mult_c_q    <= mult_c_d;
      mult_d_q    <= mult_d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  cim_shift_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .add   (acc_add),
    .sub   (acc_sub),
    .addend(addend),
    .acc   (result)
  );

  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign mult_c    = mult_c_q;
  assign mult_d    = mult_d_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cim_oai_mac_seq.sv
// Directed + scoreboard bench for cim_oai_mac_seq with a behavioural OAI multiplier cell.
module tb_cim_oai_mac_seq;

  localparam int ACT_W = 4;
  localparam int W_W   = 4;
  localparam int ACC_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W_W-1:0]   w0 = '0, w1 = '0;
  logic [ACT_W-1:0] x0 = '0, x1 = '0;
  logic [W_W-1:0]   mult_a, mult_b, mult_e;
  logic             mult_c, mult_d;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] result;

  int total = 0;
  int bad   = 0;
  logic [ACC_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Behavioural OAI cell: e = ~((a|{4{c}}) & (b|{4{d}})).
  assign mult_e = ~((mult_a | {W_W{mult_c}}) & (mult_b | {W_W{mult_d}}));

  cim_oai_mac_seq #(.ACT_W(ACT_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .w0(w0), .w1(w1), .x0(x0), .x1(x1),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_d(mult_d), .mult_e(mult_e),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  function automatic logic [ACC_W-1:0] model(input int a0, input int b0, input int a1, input int b1);
    int s0 = b0;
    int s1 = b1;
`ifdef SIGNED_ACT_EN
    if (b0 >= 8) s0 = b0 - 16;
    if (b1 >= 8) s1 = b1 - 16;
`endif
    return ACC_W'(a0 * s0 + a1 * s1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input int a0, input int b0, input int a1, input int b1);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    w0 = W_W'(a0); x0 = ACT_W'(b0); w1 = W_W'(a1); x1 = ACT_W'(b1);
    in_valid = 1'b1;
    exp_q.push_back(model(a0, b0, a1, b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid (out_ready held high), checks latency, result and the handshake.
  task automatic wait_result(input string tag, input bit chk_lat);
    int n = 0;
    logic [ACC_W-1:0] e;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check({tag, "_out_valid"}, 32'(out_valid), 1);
    if (!out_valid) return;
    if (chk_lat) check({tag, "_latency"}, n, 2 * ACT_W + 1);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, "_result"}, 32'(result), 32'(e));
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
  endtask

  initial begin
    logic [ACC_W-1:0] e;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_mult_a", 32'(mult_a), 32'hF);
    check("rst_mult_b", 32'(mult_b), 32'hF);
    check("rst_mult_c", 32'(mult_c), 1);
    check("rst_mult_d", 32'(mult_d), 1);
    check("rst_mult_e", 32'(mult_e), 0);
    @(negedge clk);
    rst = 1'b0;

    send("basic", 6, 5, 3, 7);
    check("basic_model", 32'(exp_q[0]), 51);
    wait_result("basic", 1'b1);

    send("max", 15, 15, 15, 15);
`ifdef SIGNED_ACT_EN
    check("max_model", 32'(exp_q[0]), 32'(ACC_W'(-30)));
`else
    check("max_model", 32'(exp_q[0]), 450);
`endif
    wait_result("max", 1'b1);

    send("zero", 0, 0, 0, 0);
    wait_result("zero", 1'b1);

    send("neg1", 15, 15, 3, 7);
`ifdef SIGNED_ACT_EN
    check("neg1_model", 32'(exp_q[0]), 6);
`else
    check("neg1_model", 32'(exp_q[0]), 246);
`endif
    wait_result("neg1", 1'b0);

    send("min", 15, 8, 15, 8);
`ifdef SIGNED_ACT_EN
    check("min_model", 32'(exp_q[0]), 32'(ACC_W'(-240)));
`else
    check("min_model", 32'(exp_q[0]), 240);
`endif
    wait_result("min", 1'b0);

    // Backpressure: hold out_ready low in DONE while offering another operand set.
    out_ready = 1'b0;
    send("bp", 6, 5, 3, 7);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 40);
    end
    check("bp_out_valid", 32'(out_valid), 1);
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_result", 32'(result), 32'(e));
      check("bp_hold_in_ready", 32'(in_ready), 0);
      w0 = 4'd1; x0 = 4'd1; w1 = 4'd1; x1 = 4'd1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) check("bp_result", 32'(result), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    check("bp_valid_drop", 32'(out_valid), 0);
    check("bp_in_ready", 32'(in_ready), 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_no_second_op", 32'(seen), 0);

    // Reset in the middle of RUN.
    send("midrst", 15, 15, 15, 15);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_mult_c", 32'(mult_c), 1);
    check("midrst_mult_d", 32'(mult_d), 1);
    check("midrst_mult_a", 32'(mult_a), 32'hF);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 0);
    send("fresh", 2, 9, 13, 3);
    wait_result("fresh", 1'b1);

    for (int i = 0; i < 6; i++) begin
      send("rand", $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
      wait_result("rand", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
